// File: rtl/jtag_tap_responder.sv
// JTAG TAP responder running in the clk_in domain (oversampled tck/tms/tdi/trst) with IDCODE,
// BYPASS and a 32-bit USERDATA register. Define JTAG_TAP_STATE_OUT_EN to expose tap_state_o.
module jtag_tap_responder #(
  parameter logic [31:0]         IDCODE_VALUE   = 32'h10C0_0001,
  parameter int unsigned         IR_WIDTH       = 5,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE   = IR_WIDTH'(5'h01),
  parameter logic [IR_WIDTH-1:0] INSTR_USERDATA = IR_WIDTH'(5'h10),
  parameter logic [IR_WIDTH-1:0] INSTR_BYPASS   = IR_WIDTH'(5'h1F)
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        jtag_tck,
  input  logic        jtag_tms,
  input  logic        jtag_tdi,
  input  logic        jtag_trst,
  output logic        jtag_tdo,
  output logic        jtag_tdo_oe,
`ifdef JTAG_TAP_STATE_OUT_EN
  output logic [3:0]  tap_state_o,
`endif
  input  logic [31:0] user_data_i,
  output logic [31:0] user_data_o,
  output logic        user_data_valid_o
);

  typedef enum logic [3:0] {
    TLR    = 4'h0, RTI    = 4'h1, SEL_DR = 4'h2, CAP_DR = 4'h3,
    SH_DR  = 4'h4, EX1_DR = 4'h5, PA_DR  = 4'h6, EX2_DR = 4'h7,
    UPD_DR = 4'h8, SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR  = 4'hB,
    EX1_IR = 4'hC, PA_IR  = 4'hD, EX2_IR = 4'hE, UPD_IR = 4'hF
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(5'b00101);

  logic [1:0]          tck_sync_q;
  logic                tck_prev_q;
  logic [1:0]          tms_sync_q;
  logic [1:0]          tdi_sync_q;
  logic [1:0]          trst_sync_q;
  logic                tck_rise_s;
  logic                tck_fall_s;
  logic                tms_s;
  logic                tdi_s;
  logic                trst_n_s;

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [31:0]         dr_shift_q, dr_shift_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic                tdo_oe_q, tdo_oe_d;
  logic [31:0]         user_data_q, user_data_d;
  logic                valid_q, valid_d;
  logic                sel_idcode_s;
  logic                sel_user_s;

  // Two-flop synchronisers for all JTAG pins plus a third tck flop for edge detection.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tck_sync_q  <= 2'b00;
      tck_prev_q  <= 1'b0;
      tms_sync_q  <= 2'b00;
      tdi_sync_q  <= 2'b00;
      trst_sync_q <= 2'b00;
    end else begin
      tck_sync_q  <= {tck_sync_q[0], jtag_tck};
      tck_prev_q  <= tck_sync_q[1];
      tms_sync_q  <= {tms_sync_q[0], jtag_tms};
      tdi_sync_q  <= {tdi_sync_q[0], jtag_tdi};
      trst_sync_q <= {trst_sync_q[0], jtag_trst};
    end
  end

  assign tck_rise_s   = tck_sync_q[1] & ~tck_prev_q;
  assign tck_fall_s   = ~tck_sync_q[1] & tck_prev_q;
  assign tms_s        = tms_sync_q[1];
  assign tdi_s        = tdi_sync_q[1];
  assign trst_n_s     = trst_sync_q[1];
  assign sel_idcode_s = (ir_q == INSTR_IDCODE);
  assign sel_user_s   = (ir_q == INSTR_USERDATA);

  // TAP state transitions plus per-state register actions; tms/tdi are aligned with the tck edge.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    ir_shift_d  = ir_shift_q;
    dr_shift_d  = dr_shift_q;
    bypass_d    = bypass_q;
    tdo_d       = tdo_q;
    tdo_oe_d    = tdo_oe_q;
    user_data_d = user_data_q;
    valid_d     = 1'b0;

    if (!trst_n_s) begin
      state_d    = TLR;
      ir_d       = INSTR_IDCODE;
      ir_shift_d = '0;
      dr_shift_d = '0;
      bypass_d   = 1'b0;
      tdo_oe_d   = 1'b0;
    end else if (tck_rise_s) begin
      case (state_q)
        TLR:     state_d = tms_s ? TLR    : RTI;
        RTI:     state_d = tms_s ? SEL_DR : RTI;
        SEL_DR:  state_d = tms_s ? SEL_IR : CAP_DR;
        CAP_DR:  state_d = tms_s ? EX1_DR : SH_DR;
        SH_DR:   state_d = tms_s ? EX1_DR : SH_DR;
        EX1_DR:  state_d = tms_s ? UPD_DR : PA_DR;
        PA_DR:   state_d = tms_s ? EX2_DR : PA_DR;
        EX2_DR:  state_d = tms_s ? UPD_DR : SH_DR;
        UPD_DR:  state_d = tms_s ? SEL_DR : RTI;
        SEL_IR:  state_d = tms_s ? TLR    : CAP_IR;
        CAP_IR:  state_d = tms_s ? EX1_IR : SH_IR;
        SH_IR:   state_d = tms_s ? EX1_IR : SH_IR;
        EX1_IR:  state_d = tms_s ? UPD_IR : PA_IR;
        PA_IR:   state_d = tms_s ? EX2_IR : PA_IR;
        EX2_IR:  state_d = tms_s ? UPD_IR : SH_IR;
        UPD_IR:  state_d = tms_s ? SEL_DR : RTI;
        default: state_d = TLR;
      endcase

      case (state_q)
        CAP_IR: ir_shift_d = IR_CAPTURE;
        SH_IR:  ir_shift_d = {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
        UPD_IR: ir_d       = ir_shift_q;
        CAP_DR: begin
          if (sel_idcode_s) begin
            dr_shift_d = IDCODE_VALUE;
          end else if (sel_user_s) begin
            dr_shift_d = user_data_i;
          end else begin
            bypass_d = 1'b0;
          end
        end
        SH_DR: begin
          if (sel_idcode_s || sel_user_s) begin
            dr_shift_d = {tdi_s, dr_shift_q[31:1]};
          end else begin
            bypass_d = tdi_s;
          end
        end
        UPD_DR: begin
          if (sel_user_s) begin
            user_data_d = dr_shift_q;
            valid_d     = 1'b1;
          end else begin
            user_data_d = user_data_q;
          end
        end
        default: ir_shift_d = ir_shift_q;
      endcase

      // Any path into Test-Logic-Reset reselects IDCODE.
      ir_d = (state_d == TLR) ? INSTR_IDCODE : ir_d;
    end else if (tck_fall_s) begin
      tdo_oe_d = (state_q == SH_IR) || (state_q == SH_DR);
      if (state_q == SH_IR) begin
        tdo_d = ir_shift_q[0];
      end else if (state_q == SH_DR) begin
        tdo_d = (sel_idcode_s || sel_user_s) ? dr_shift_q[0] : bypass_q;
      end else begin
        tdo_d = tdo_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // TAP state, instruction, shift and output registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= TLR;
      ir_q        <= INSTR_IDCODE;
      ir_shift_q  <= '0;
      dr_shift_q  <= 32'h0000_0000;
      bypass_q    <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_oe_q    <= 1'b0;
      user_data_q <= 32'h0000_0000;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_shift_q  <= ir_shift_d;
      dr_shift_q  <= dr_shift_d;
      bypass_q    <= bypass_d;
      tdo_q       <= tdo_d;
      tdo_oe_q    <= tdo_oe_d;
      user_data_q <= user_data_d;
      valid_q     <= valid_d;
    end
  end

  assign jtag_tdo          = tdo_q;
  assign jtag_tdo_oe       = tdo_oe_q;
  assign user_data_o       = user_data_q;
  assign user_data_valid_o = valid_q;

`ifdef JTAG_TAP_STATE_OUT_EN
  assign tap_state_o = state_q;
`endif

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Randomised bench for jtag_tap_responder: scan-level model of IR/DR capture, shift and update.
module tb_jtag_tap_responder;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        jtag_tck;
  logic        jtag_tms;
  logic        jtag_tdi;
  logic        jtag_trst;
  logic        jtag_tdo;
  logic        jtag_tdo_oe;
  logic [31:0] user_data_i;
  logic [31:0] user_data_o;
  logic        user_data_valid_o;

  localparam logic [31:0] IDC = 32'h10C0_0001;

  int          checks   = 0;
  int          failures = 0;
  int          half     = 4;
  int          pulses   = 0;
  logic [4:0]  ir_m;
  logic [31:0] ud_m;

  jtag_tap_responder dut (
    .clk_in            (clk_in),
    .reset             (reset),
    .jtag_tck          (jtag_tck),
    .jtag_tms          (jtag_tms),
    .jtag_tdi          (jtag_tdi),
    .jtag_trst         (jtag_trst),
    .jtag_tdo          (jtag_tdo),
    .jtag_tdo_oe       (jtag_tdo_oe),
    .user_data_i       (user_data_i),
    .user_data_o       (user_data_o),
    .user_data_valid_o (user_data_valid_o)
  );

  always #5 clk_in = ~clk_in;

  // Counts clk_in cycles with the valid strobe high.
  always @(negedge clk_in) begin
    if (user_data_valid_o === 1'b1) pulses++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int n);
    logic [63:0] m;
    m = (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    return m;
  endfunction

  function automatic int dr_width(input logic [4:0] ir);
    return (ir == 5'h01 || ir == 5'h10) ? 32 : 1;
  endfunction

  function automatic logic [31:0] dr_cap(input logic [4:0] ir, input logic [31:0] ud);
    if (ir == 5'h01) return IDC;
    if (ir == 5'h10) return ud;
    return 32'h0;
  endfunction

  task automatic tbit(input logic tms, input logic tdi, output logic tdo_s, output logic oe_s);
    jtag_tms = tms;
    jtag_tdi = tdi;
    repeat (half) @(negedge clk_in);
    tdo_s = jtag_tdo;
    oe_s  = jtag_tdo_oe;
    jtag_tck = 1'b1;
    repeat (half) @(negedge clk_in);
    jtag_tck = 1'b0;
  endtask

  task automatic step(input logic tms);
    logic a, b;
    tbit(tms, 1'b0, a, b);
  endtask

  task automatic tap_reset();
    repeat (5) step(1'b1);
    step(1'b0);
    ir_m = 5'h01;
  endtask

  // From Run-Test/Idle: one full IR or DR scan, optionally pausing after bit pause_at-1.
  task automatic scan(input logic is_ir, input int n, input logic [63:0] din, input int pause_at,
                      input int pause_len, output logic [63:0] dout, output logic oe_ok);
    logic t, o, last;
    dout  = '0;
    oe_ok = 1'b1;
    step(1'b1);
    if (is_ir) step(1'b1);
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1) || (i == pause_at - 1);
      tbit(last, din[i], t, o);
      dout[i] = t;
      if (o !== 1'b1) oe_ok = 1'b0;
      if (i == pause_at - 1 && i != n - 1) begin
        tbit(1'b0, 1'b0, t, o);
        if (o !== 1'b0) oe_ok = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          tbit(1'b0, 1'b0, t, o);
          if (o !== 1'b0) oe_ok = 1'b0;
        end
        tbit(1'b1, 1'b0, t, o);
        if (o !== 1'b0) oe_ok = 1'b0;
        tbit(1'b0, 1'b0, t, o);
        if (o !== 1'b0) oe_ok = 1'b0;
      end
    end
    tbit(1'b1, 1'b0, t, o);
    if (o !== 1'b0) oe_ok = 1'b0;
    step(1'b0);
  endtask

  task automatic ir_scan(input string tag, input logic [4:0] op);
    logic [63:0] dout;
    logic        ok;
    scan(1'b1, 5, {59'd0, op}, 0, 0, dout, ok);
    check({tag, "_ircap"}, dout, 64'h05);
    check({tag, "_iroe"}, {63'd0, ok}, 64'd1);
    ir_m = op;
  endtask

  task automatic dr_scan(input string tag, input int n, input logic [63:0] din,
                         input int pause_at, input int pause_len);
    logic [63:0]  dout;
    logic         ok;
    logic [127:0] stream;
    logic [127:0] rest;
    int           w;
    int           p0;
    int           exp_p;
    w      = dr_width(ir_m);
    stream = ({64'd0, din} << w) | {96'd0, dr_cap(ir_m, user_data_i)};
    p0     = pulses;
    scan(1'b0, n, din, pause_at, pause_len, dout, ok);
    check({tag, "_tdo"}, dout, stream[63:0] & mask(n));
    check({tag, "_oe"}, {63'd0, ok}, 64'd1);
    exp_p = 0;
    if (ir_m == 5'h10) begin
      rest  = stream >> n;
      ud_m  = rest[31:0];
      exp_p = 1;
    end
    check({tag, "_pulses"}, 64'(pulses - p0), 64'(exp_p));
    check({tag, "_udo"}, {32'd0, user_data_o}, {32'd0, ud_m});
  endtask

  initial begin
    logic t, o;
    int   sel;
    int   n;
    int   p0;
    logic [4:0] op;
    jtag_tck = 1'b0; jtag_tms = 1'b1; jtag_tdi = 1'b0; jtag_trst = 1'b1;
    user_data_i = 32'h0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_outs", {28'd0, jtag_tdo, jtag_tdo_oe, user_data_valid_o, 1'b0, user_data_o}, 64'd0);
    reset = 1'b1;
    ud_m  = 32'h0;
    repeat (3) @(negedge clk_in);

    tap_reset();
    dr_scan("idcode", 32, {$urandom, $urandom}, 0, 0);

    ir_scan("byp", 5'h1F);
    dr_scan("byp8", 8, 64'hA5, 0, 0);

    ir_scan("usr", 5'h10);
    user_data_i = 32'hCAFE_F00D;
    dr_scan("usr32", 32, 64'h1234_5678, 0, 0);

    // TAP reset pin asserted mid-shift of USERDATA.
    p0 = pulses;
    step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < 10; i++) tbit(1'b0, 1'($urandom), t, o);
    jtag_trst = 1'b0;
    repeat (6) @(negedge clk_in);
    check("trst_oe", {63'd0, jtag_tdo_oe}, 64'd0);
    jtag_trst = 1'b1;
    repeat (4) @(negedge clk_in);
    check("trst_pulses", 64'(pulses - p0), 64'd0);
    check("trst_udo", {32'd0, user_data_o}, {32'd0, ud_m});
    ir_m = 5'h01;
    step(1'b0);
    dr_scan("trst_idc", 32, {$urandom, $urandom}, 0, 0);

    // Asynchronous reset mid-shift of USERDATA.
    ir_scan("ar", 5'h10);
    user_data_i = $urandom;
    dr_scan("ar_pre", 32, {32'd0, $urandom}, 0, 0);
    step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < 5; i++) tbit(1'b0, 1'($urandom), t, o);
    @(negedge clk_in);
    reset = 1'b0;
    #1;
    check("areset_outs", {28'd0, jtag_tdo, jtag_tdo_oe, user_data_valid_o, 1'b0, user_data_o}, 64'd0);
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    ud_m = 32'h0;
    ir_m = 5'h01;
    repeat (3) @(negedge clk_in);
    step(1'b0);
    dr_scan("ar_idc", 32, {$urandom, $urandom}, 0, 0);

    // Minimum tck half-period round trip through USERDATA.
    half = 4;
    ir_scan("rt", 5'h10);
    user_data_i = $urandom;
    dr_scan("rt1", 32, {32'd0, $urandom}, 0, 0);
    user_data_i = ud_m;
    dr_scan("rt2", 32, {32'd0, $urandom}, 0, 0);

    for (int k = 0; k < 10; k++) begin
      half = $urandom_range(4, 7);
      sel  = $urandom_range(0, 3);
      op   = (sel == 0) ? 5'h01 : (sel == 1) ? 5'h10 : (sel == 2) ? 5'h1F : 5'($urandom);
      ir_scan("rnd", op);
      user_data_i = $urandom;
      n = $urandom_range(1, 48);
      dr_scan("rnd", n, {$urandom, $urandom}, $urandom_range(0, n), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
